// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-bit layout
// and the opcode/funct encodings used by decode.
package mips_pkg;

  localparam int CTRL_W        = 9;
  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMREAD  = 7;
  localparam int CTRL_MEMWRITE = 6;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_REGDST   = 3;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  function automatic logic is_load(
    input logic [CTRL_W-1:0] c
  );
    return c[CTRL_MEMREAD];
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: EX holds a load whose rt is a
// source of the instruction currently in ID.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              stall
);

  // r0 is a real register here, so no zero-address exclusion
  assign stall = ex_valid & ex_memread & id_valid &
                 ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB bypass, load-use
// stall and branch flush.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_wa,
  input  logic [DATA_W-1:0] wb_wd,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] a_in, b_in;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .ex_valid   (valid_q),
    .ex_memread (is_load(ctrl_q)),
    .ex_rt      (rt_q),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .stall      (stall)
  );

  // regfile writes at the edge; ID sees the stale value
  assign a_in = (wb_regwrite && wb_wa == id_rs)
                ? wb_wd : id_rd1;
  assign b_in = (wb_regwrite && wb_wa == id_rt)
                ? wb_wd : id_rd2;

  always_comb begin
    valid_d = 1'b0;
    a_d     = '0;
    b_d     = '0;
    imm_d   = '0;
    rs_d    = '0;
    rt_d    = '0;
    rd_d    = '0;
    ctrl_d  = '0;
    if (!flush && !stall && id_valid) begin
      valid_d = 1'b1;
      a_d     = a_in;
      b_d     = b_in;
      imm_d   = id_imm;
      rs_d    = id_rs;
      rt_d    = id_rt;
      rd_d    = id_rd;
      ctrl_d  = id_ctrl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign ex_valid = valid_q;
  assign ex_a     = a_q;
  assign ex_b     = b_q;
  assign ex_imm   = imm_q;
  assign ex_rs    = rs_q;
  assign ex_rt    = rt_q;
  assign ex_rd    = rd_q;
  assign ex_ctrl  = ctrl_q;

endmodule
